// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between a master and the register-file completer.
// Clock and reset stay outside the bundle as plain ports.
interface apb_slave_regfile_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic                  pready;
  logic [DATA_W-1:0]     prdata;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer backed by a byte-strobed register file.
// Setup beat is latched in IDLE, WAIT_STATES low-PREADY cycles follow,
// then a single registered PREADY pulse carries PRDATA/PSLVERR.
// Writes commit on the completion edge; erroring or aborted writes never commit.
module apb_slave_regfile #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic               pclk,
  input  logic               preset_n,
  apb_slave_regfile_if.slave bus
);

  localparam int STRB_W    = DATA_W / 8;
  localparam int IDX_W     = ADDR_W - 2;
  localparam int REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;

  // Transfer attributes captured at the setup edge
  logic                   pwrite_q;
  logic [REG_IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [STRB_W-1:0]      strb_q;
  logic                   err_q;

  // Registered response
  logic                   pready_q;
  logic [DATA_W-1:0]      prdata_q;
  logic                   pslverr_q;

  logic [DATA_W-1:0]      regs [NUM_REGS];

  // Setup-beat decode: word index and error check on the live address
  logic                   setup_beat;
  logic                   err_now;
  logic [REG_IDX_W-1:0]   idx_now;

  assign setup_beat = bus.psel && !bus.penable;
  assign idx_now    = bus.paddr[2 +: REG_IDX_W];
  assign err_now    = (bus.paddr[1:0] != 2'b00) ||
                      ({1'b0, bus.paddr[ADDR_W-1:2]} >= (IDX_W + 1)'(NUM_REGS));

  logic                   load;
  logic                   commit;
  logic                   pready_d;

  // Next-state, wait countdown and PREADY scheduling
  // NOTE: every signal assigned here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pready_d = 1'b0;
    load     = 1'b0;
    commit   = 1'b0;
    case (state_q)
      IDLE: begin
        // PSEL with PENABLE already high is not a setup beat and is ignored
        if (setup_beat) begin
          state_d  = ACCESS;
          load     = 1'b1;
          cnt_d    = 4'(WAIT_STATES);
          pready_d = (WAIT_STATES == 0);
        end
      end
      ACCESS: begin
        if (pready_q) begin
          // Completion cycle: the write lands only if the master still holds the access
          state_d = IDLE;
          commit  = bus.psel && bus.penable && pwrite_q && !err_q;
        end else if (!bus.psel) begin
          // Master abandoned the transfer before completion
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != 4'd0) begin
          cnt_d    = cnt_q - 4'd1;
          pready_d = (cnt_q == 4'd1);
        end else begin
          pready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response data: with zero wait states the read happens on the setup edge,
  // so the live address is used instead of the not-yet-latched one
  logic [REG_IDX_W-1:0]   rd_idx;
  logic                   rd_err;
  logic                   rd_write;
  logic [DATA_W-1:0]      prdata_d;
  logic                   pslverr_d;

  // Select read source and force PRDATA/PSLVERR to zero outside the PREADY cycle
  always_comb begin
    rd_idx    = load ? idx_now    : idx_q;
    rd_err    = load ? err_now    : err_q;
    rd_write  = load ? bus.pwrite : pwrite_q;
    prdata_d  = '0;
    pslverr_d = 1'b0;
    if (pready_d) begin
      pslverr_d = rd_err;
      if (!rd_write && !rd_err) begin
        prdata_d = regs[rd_idx];
      end
    end
  end

  // FSM state, counter, captured transfer and registered response
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      pwrite_q  <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      if (load) begin
        pwrite_q <= bus.pwrite;
        idx_q    <= idx_now;
        wdata_q  <= bus.pwdata;
        strb_q   <= bus.pstrb;
        err_q    <= err_now;
      end
    end
  end

  // Register file: cleared on reset, byte-lane writes on commit
  // NOTE: the registers must read back as zero after reset, so the array is
  // reset explicitly; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
    end else if (commit) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (strb_q[i]) begin
          regs[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign bus.pready  = pready_q;
  assign bus.prdata  = prdata_q;
  assign bus.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile. Two instances share one stimulus
// master: one with three wait states, one with zero; use0 routes the bus.
module tb_apb_slave_regfile;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  bit          use0;

  always #5 pclk = ~pclk;

  apb_slave_regfile_if #(.ADDR_W(8), .DATA_W(32)) bus3 ();
  apb_slave_regfile_if #(.ADDR_W(8), .DATA_W(32)) bus0 ();

  assign bus3.psel    = psel && !use0;
  assign bus3.penable = penable;
  assign bus3.pwrite  = pwrite;
  assign bus3.paddr   = paddr;
  assign bus3.pwdata  = pwdata;
  assign bus3.pstrb   = pstrb;

  assign bus0.psel    = psel && use0;
  assign bus0.penable = penable;
  assign bus0.pwrite  = pwrite;
  assign bus0.paddr   = paddr;
  assign bus0.pwdata  = pwdata;
  assign bus0.pstrb   = pstrb;

  apb_slave_regfile #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(16), .WAIT_STATES(3)) dut3 (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (bus3)
  );

  apb_slave_regfile #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(16), .WAIT_STATES(0)) dut0 (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (bus0)
  );

  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  assign pready  = use0 ? bus0.pready  : bus3.pready;
  assign prdata  = use0 ? bus0.prdata  : bus3.prdata;
  assign pslverr = use0 ? bus0.pslverr : bus3.pslverr;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Expected PREADY latency counted from the setup cycle: 1 + WAIT_STATES
  function automatic int exp_lat();
    return use0 ? 1 : 4;
  endfunction

  // One APB transfer, entered and left just after a rising edge.
  // lat is the number of cycles from setup to the PREADY cycle, -1 on timeout.
  task automatic xfer(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, output logic [31:0] rdata,
                      output logic err, output int lat, output bit quiet);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    lat = -1; rdata = 'x; err = 1'bx; quiet = 1'b1;
    @(posedge pclk); #1;
    penable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge pclk);
      if (pready === 1'b1) begin
        rdata = prdata;
        err   = pslverr;
        lat   = k;
        break;
      end
      if (prdata !== 32'h0 || pslverr !== 1'b0) quiet = 1'b0;
      @(posedge pclk); #1;
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apb_write(input string tag, input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input bit exp_err);
    logic [31:0] rdata;
    logic        err;
    int          lat;
    bit          quiet;
    xfer(1'b1, addr, data, strb, rdata, err, lat, quiet);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat()));
    check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    check({tag, "_quiet"}, {31'b0, quiet}, 32'd1);
  endtask

  task automatic apb_read(input string tag, input logic [7:0] addr,
                          input logic [31:0] exp_data, input bit exp_err);
    logic [31:0] rdata;
    logic        err;
    int          lat;
    bit          quiet;
    xfer(1'b0, addr, 32'h0, 4'h0, rdata, err, lat, quiet);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat()));
    check({tag, "_data"}, rdata, exp_data);
    check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    check({tag, "_quiet"}, {31'b0, quiet}, 32'd1);
  endtask

  // Count PREADY pulses over n cycles; entered and left just after a rising edge
  task automatic count_pready(input int n, output int pulses);
    pulses = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge pclk);
      if (pready !== 1'b0) pulses++;
      @(posedge pclk); #1;
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    use0 = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h0; pwdata = 32'h0; pstrb = 4'h0;
    preset_n = 1'b0;

    // Reset state
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    check("rst_pready",  {31'b0, pready},  32'h0);
    check("rst_prdata",  prdata,           32'h0);
    check("rst_pslverr", {31'b0, pslverr}, 32'h0);
    @(posedge pclk); #1;
    preset_n = 1'b1;

    // Reset clears a written register
    apb_write("w_dead", 8'h04, 32'hDEADBEEF, 4'hF, 1'b0);
    apb_read ("r_dead", 8'h04, 32'hDEADBEEF, 1'b0);
    preset_n = 1'b0;
    @(posedge pclk); #1;
    preset_n = 1'b1;
    @(negedge pclk);
    check("rst2_pready",  {31'b0, pready},  32'h0);
    check("rst2_prdata",  prdata,           32'h0);
    check("rst2_pslverr", {31'b0, pslverr}, 32'h0);
    @(posedge pclk); #1;
    apb_read("r_after_rst", 8'h04, 32'h0, 1'b0);

    // Byte strobes: lanes 0 and 2 overwritten, lanes 1 and 3 kept
    apb_write("w_ones", 8'h08, 32'hFFFFFFFF, 4'hF,    1'b0);
    apb_write("w_strb", 8'h08, 32'h12345678, 4'b0101, 1'b0);
    apb_read ("r_strb", 8'h08, 32'hFF34FF78, 1'b0);
    @(negedge pclk);
    check("pready_one_cycle", {31'b0, pready}, 32'h0);
    @(posedge pclk); #1;

    // Errors: misaligned, out of range, erroring read; nothing modified
    apb_write("w_misalign", 8'h41, 32'hAAAA5555, 4'hF, 1'b1);
    apb_write("w_range",    8'h40, 32'hAAAA5555, 4'hF, 1'b1);
    apb_read ("r_range",    8'h40, 32'h0,        1'b1);
    apb_read ("r_misalign", 8'h0A, 32'h0,        1'b1);
    apb_read ("r_reg0_kept", 8'h00, 32'h0,        1'b0);
    apb_read ("r_reg2_kept", 8'h08, 32'hFF34FF78, 1'b0);

    // Zero strobe is a legal no-op write
    apb_write("w_nostrb", 8'h08, 32'h00000000, 4'h0, 1'b0);
    apb_read ("r_nostrb", 8'h08, 32'hFF34FF78, 1'b0);

    // Abort: PSEL drops during the wait states of a write
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h11; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    count_pready(6, pulses);
    check("abort_no_pready", 32'(pulses), 32'h0);
    apb_read("r_abort", 8'h0C, 32'h0, 1'b0);

    // Stray PENABLE without a setup beat
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h22; pstrb = 4'hF;
    count_pready(6, pulses);
    psel = 1'b0; penable = 1'b0;
    check("stray_no_pready", 32'(pulses), 32'h0);
    apb_read("r_stray", 8'h0C, 32'h0, 1'b0);

    // Back-to-back write then read, three wait states
    apb_write("w_b2b", 8'h00, 32'h00000001, 4'hF, 1'b0);
    apb_read ("r_b2b", 8'h00, 32'h00000001, 1'b0);

    // Zero wait states: PREADY in the first access cycle, back-to-back
    use0 = 1'b1;
    apb_write("w0_b2b", 8'h14, 32'hA5A5A5A5, 4'hF, 1'b0);
    apb_read ("r0_b2b", 8'h14, 32'hA5A5A5A5, 1'b0);
    @(negedge pclk);
    check("w0_pready_one_cycle", {31'b0, pready}, 32'h0);
    @(posedge pclk); #1;
    apb_write("w0_err", 8'h42, 32'h5A5A5A5A, 4'hF, 1'b1);
    apb_read ("r0_kept", 8'h14, 32'hA5A5A5A5, 1'b0);
    use0 = 1'b0;

    // Reset during the access phase of a write; master keeps the access up afterwards
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'h55; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    preset_n = 1'b0;
    @(posedge pclk); #1;
    preset_n = 1'b1;
    count_pready(6, pulses);
    psel = 1'b0; penable = 1'b0;
    check("rst_mid_no_pready", 32'(pulses), 32'h0);
    apb_read("r_rst_mid",   8'h10, 32'h0, 1'b0);
    apb_read("r_rst_reg0",  8'h00, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
